// File: rtl/dram_cmd_timer.sv
// dram_cmd_timer: DRAM command timing and bank-state checker behind a four-phase cmd_req/cmd_ack handshake
module dram_cmd_timer #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int T_RCD        = 3,
    parameter int T_CL         = 2,
    parameter int T_WR         = 2,
    parameter int T_RP         = 3,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_req,
    input  logic [1:0]                      cmd,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  row_id,
    output logic                            cmd_ack,
    output logic                            cmd_err,
    output logic                            rd_strobe,
    output logic                            wr_strobe,
    output logic [NUM_OF_BANKS-1:0]         bank_open,
    output logic                            busy
);
    localparam int BW = $clog2(NUM_OF_BANKS);
    localparam int RW = $clog2(NUM_OF_ROWS);
    localparam logic [1:0] ACT = 2'b00, RD = 2'b01, WR = 2'b10, PRE = 2'b11;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t state, state_d;
    logic [CNT_WIDTH-1:0] cnt, delay;
    logic [1:0] cmd_q;
    logic [BW-1:0] bank_q;
    logic [RW-1:0] row_q;
    logic err_q, illegal, accept, done;
    logic [RW-1:0] open_row [NUM_OF_BANKS];

    assign busy = state != IDLE;

    always_comb begin
        accept = state == IDLE && cmd_req && !cmd_ack;
        done = state == WAIT && cnt == '0;
        illegal = cmd == ACT ? bank_open[bank_id] :
                  cmd == PRE ? 1'b0 : !(bank_open[bank_id] && open_row[bank_id] == row_id);
        // illegal commands complete on the very next edge
        delay = illegal ? '0 :
                cmd == ACT ? CNT_WIDTH'(T_RCD - 1) :
                cmd == RD ? CNT_WIDTH'(T_CL - 1) :
                cmd == WR ? CNT_WIDTH'(T_WR - 1) : CNT_WIDTH'(T_RP - 1);
        state_d = accept ? WAIT : done ? ACK : (state == ACK && !cmd_req) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            cmd_q <= ACT;
            bank_q <= '0;
            row_q <= '0;
            err_q <= 1'b0;
            cmd_ack <= 1'b0;
            cmd_err <= 1'b0;
            rd_strobe <= 1'b0;
            wr_strobe <= 1'b0;
            bank_open <= '0;
            open_row <= '{default: '0};
        end else begin
            state <= state_d;
            rd_strobe <= 1'b0;
            wr_strobe <= 1'b0;
            if (accept) begin
                cmd_q <= cmd;
                bank_q <= bank_id;
                row_q <= row_id;
                err_q <= illegal;
                cnt <= delay;
            end
            if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (done) begin
                cmd_ack <= 1'b1;
                cmd_err <= err_q;
                rd_strobe <= !err_q && cmd_q == RD;
                wr_strobe <= !err_q && cmd_q == WR;
                if (!err_q && cmd_q == ACT) begin
                    bank_open[bank_q] <= 1'b1;
                    open_row[bank_q] <= row_q;
                end
                if (!err_q && cmd_q == PRE)
                    bank_open[bank_q] <= 1'b0;
            end
            if (state == ACK && !cmd_req) begin
                cmd_ack <= 1'b0;
                cmd_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dram_cmd_timer.sv
// tb_dram_cmd_timer: four-phase master with a bank-state reference model and a scoreboard monitor
module tb_dram_cmd_timer;
    localparam int NB = 8, NR = 128, T_RCD = 3, T_CL = 2, T_WR = 2, T_RP = 3;

    logic clk = 1'b0, rst = 1'b1, cmd_req = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [2:0] bank_id = '0;
    logic [6:0] row_id = '0;
    logic cmd_ack, cmd_err, rd_strobe, wr_strobe, busy;
    logic [NB-1:0] bank_open;

    dram_cmd_timer #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .T_RCD(T_RCD), .T_CL(T_CL),
                     .T_WR(T_WR), .T_RP(T_RP), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd(cmd), .bank_id(bank_id), .row_id(row_id),
        .cmd_ack(cmd_ack), .cmd_err(cmd_err), .rd_strobe(rd_strobe), .wr_strobe(wr_strobe),
        .bank_open(bank_open), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int issue;
        int lat;
        bit err;
        bit rd;
        bit wr;
        logic [NB-1:0] banks;
    } exp_t;
    exp_t sb[$];

    int checks = 0, fails = 0, cyc = 0;
    int rd_seen = 0, wr_seen = 0, rd_exp = 0, wr_exp = 0;
    bit m_open[NB];
    int m_row[NB];
    logic ack_prev = 1'b0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc++;

    // scoreboard monitor: every rising ack retires the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (cmd_ack && !ack_prev) begin
            if (sb.size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                e = sb.pop_front();
                chk("latency", cyc - e.issue, e.lat);
                chk("cmd_err", cmd_err, e.err);
                chk("rd_strobe", rd_strobe, e.rd);
                chk("wr_strobe", wr_strobe, e.wr);
                chk("bank_open", bank_open, e.banks);
            end
        end else if (rd_strobe || wr_strobe) chk("stray_strobe", {rd_strobe, wr_strobe}, 0);
        if (rd_strobe) rd_seen++;
        if (wr_strobe) wr_seen++;
        ack_prev = cmd_ack;
    end

    task automatic issue(input logic [1:0] c, input int b, input int r, input int rel, input bit early);
        exp_t e;
        int n = 0;
        e.err = c == 2'd0 ? m_open[b] : (c == 2'd3 ? 1'b0 : !(m_open[b] && m_row[b] == r));
        e.lat = e.err ? 1 : c == 2'd0 ? T_RCD : c == 2'd1 ? T_CL : c == 2'd2 ? T_WR : T_RP;
        e.rd = !e.err && c == 2'd1;
        e.wr = !e.err && c == 2'd2;
        if (!e.err && c == 2'd0) begin
            m_open[b] = 1'b1;
            m_row[b] = r;
        end
        if (!e.err && c == 2'd3) m_open[b] = 1'b0;
        for (int i = 0; i < NB; i++) e.banks[i] = m_open[i];
        e.issue = cyc + 1;
        rd_exp += int'(e.rd);
        wr_exp += int'(e.wr);
        sb.push_back(e);
        cmd_req = 1'b1;
        cmd = c;
        bank_id = 3'(b);
        row_id = 7'(r);
        @(negedge clk);
        cmd = 2'($urandom);
        bank_id = 3'($urandom);
        row_id = 7'($urandom);
        if (early) cmd_req = 1'b0;
        while (!cmd_ack && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ack) begin
            chk("ack_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_back());
            cmd_req = 1'b0;
            return;
        end
        if (!early) begin
            repeat (rel) @(negedge clk);
            chk("ack_hold", cmd_ack, 1);
            cmd_req = 1'b0;
        end
        @(negedge clk);
        chk("ack_fall", cmd_ack, 0);
    endtask

    initial begin
        int b, r;
        logic [1:0] c;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_outputs", {cmd_ack, cmd_err, rd_strobe, wr_strobe, busy, bank_open}, 0);
        repeat (4) @(negedge clk);
        issue(2'd0, 2, 5, 0, 0);
        issue(2'd1, 2, 5, 2, 0);
        issue(2'd2, 2, 5, 1, 0);
        issue(2'd1, 3, 5, 0, 0);
        issue(2'd1, 2, 6, 0, 0);
        issue(2'd0, 2, 9, 0, 0);
        issue(2'd1, 2, 5, 0, 0);
        issue(2'd3, 2, 0, 0, 0);
        issue(2'd3, 2, 0, 0, 0);
        issue(2'd0, 4, 17, 0, 1);
        issue(2'd2, 4, 17, 0, 1);
        // reset while an ACTIVATE to bank 7 is in WAIT
        cmd_req = 1'b1;
        cmd = 2'd0;
        bank_id = 3'd7;
        row_id = 7'd1;
        @(negedge clk);
        chk("busy_in_wait", busy, 1);
        rst = 1'b1;
        cmd_req = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ack", cmd_ack, 0);
        chk("rst_banks", bank_open, 0);
        rst = 1'b0;
        for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_ack_after_rst", cmd_ack, 0);
        for (int k = 0; k < 128; k++) begin
            b = $urandom_range(0, NB - 1);
            if (m_open[b]) begin
                c = 2'($urandom_range(1, 3));
                r = m_row[b];
            end else begin
                c = $urandom_range(0, 3) != 0 ? 2'd0 : 2'd3;
                r = $urandom_range(0, NR - 1);
            end
            issue(c, b, r, $urandom_range(0, 8), 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("rd_strobe_count", rd_seen, rd_exp);
        chk("wr_strobe_count", wr_seen, wr_exp);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/dram_cmd_timer.md
Name: dram_cmd_timer

Overview:
- Downstream of dram_ctrl. Consumes its cmd_req/cmd four-phase handshake and returns cmd_ack only after the DRAM timing for that command has elapsed.
- Tracks the open row of every bank. Flags illegal command sequences.
- Emits one-cycle read/write strobes towards the DRAM array (bank_rw side of dram_bfm).
- Replaces the fixed-delay handshake model currently used in simulation.

Parameters:
- NUM_OF_BANKS, 8, number of banks; bank_id width is $clog2(NUM_OF_BANKS).
- NUM_OF_ROWS, 128, rows per bank; row_id width is $clog2(NUM_OF_ROWS).
- T_RCD, 3, cycles for ACTIVATE (row open); minimum 1.
- T_CL, 2, cycles for READ; minimum 1.
- T_WR, 2, cycles for WRITE; minimum 1.
- T_RP, 3, cycles for PRECHARGE (row close); minimum 1.
- CNT_WIDTH, 4, delay counter width; every T_* must be at most 2**CNT_WIDTH.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- cmd_req, input, 1, request from dram_ctrl; held high until cmd_ack is seen.
- cmd, input, 2, command: 00 ACTIVATE, 01 READ, 10 WRITE, 11 PRECHARGE; stable while cmd_req is high.
- bank_id, input, $clog2(NUM_OF_BANKS), target bank; stable while cmd_req is high.
- row_id, input, $clog2(NUM_OF_ROWS), target row; stable while cmd_req is high.
- cmd_ack, output, 1, completion acknowledge.
- cmd_err, output, 1, protocol error; valid while cmd_ack is high.
- rd_strobe, output, 1, one-cycle pulse when a legal READ completes.
- wr_strobe, output, 1, one-cycle pulse when a legal WRITE completes.
- bank_open, output, NUM_OF_BANKS, per-bank open-row flag.
- busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: every output is 0. All banks are closed, all open-row registers are 0, FSM is in IDLE, counter is 0.
- Reset mid-operation takes priority over everything. The next edge forces all of the above. A pending command is discarded without ack.
- FSM states: IDLE, WAIT, ACK.
- IDLE: on an edge with cmd_req=1 and cmd_ack=0, latch cmd, bank_id and row_id, and perform the legality check:
  - ACTIVATE is illegal if the bank is already open.
  - READ or WRITE is illegal if the bank is closed, or if the open row differs from row_id.
  - PRECHARGE to a closed bank is legal and is a no-op on bank state.
- Delay selection: a legal command loads counter = T_x − 1, where T_x is the parameter for that command. An illegal command loads counter = 0 and sets an internal error flag.
- IDLE → WAIT on that edge.
- WAIT: the counter decrements each edge. On the edge where it is 0:
  - transition to ACK and set cmd_ack=1;
  - set cmd_err to the error flag;
  - apply the bank update if legal: ACTIVATE sets bank_open[b]=1 and open_row[b]=row; PRECHARGE clears bank_open[b];
  - pulse rd_strobe or wr_strobe for a legal READ or WRITE.
- Latency: with the request sampled at edge N, cmd_ack goes high at edge N+T_x for legal commands and at edge N+1 for illegal ones.
- rd_strobe and wr_strobe are high for exactly the first ACK cycle.
- ACK: cmd_ack and cmd_err hold. On an edge where cmd_req=0, drive cmd_ack=0 and cmd_err=0 and return to IDLE.
- A new request is accepted no earlier than the edge after cmd_ack falls, which completes the four-phase protocol.
- If cmd_req drops during WAIT (protocol violation), the command still completes. cmd_ack rises as scheduled and falls on the following edge because cmd_req is already 0.
- Changes to cmd, bank_id or row_id while busy are ignored because the values are latched.
- Only one command is in flight at a time; there is no pipelining.
- Counter arithmetic is unsigned CNT_WIDTH bits and never underflows (WAIT exits at 0).

Test Plan:
- Reset, then ACTIVATE bank 2 row 5 with req at edge 10: cmd_ack high at edge 13, bank_open=8'b0000_0100, cmd_err=0; drop req, cmd_ack low one edge later.
- After that, READ bank 2 row 5: ack 2 cycles after sampling, rd_strobe single-cycle pulse, wr_strobe=0. Then WRITE bank 2 row 5: wr_strobe pulse, ack after 2 cycles.
- READ bank 3 (closed): ack 1 cycle after sampling, cmd_err=1, no strobe, bank_open unchanged. Also READ bank 2 row 6 (row mismatch): cmd_err=1.
- ACTIVATE bank 2 while it is open: cmd_err=1 and open row stays 5. Then PRECHARGE bank 2: ack after 3 cycles, bank_open[2]=0. PRECHARGE bank 2 again: legal, cmd_err=0.
- Assert rst during WAIT of an ACTIVATE to bank 7: next edge has busy=0, cmd_ack=0, bank_open=0, and no ack ever appears for that request.
- Back-to-back 128 random legal commands driven by a four-phase master with 0–8 cycle random ack-to-release delay: a scoreboard checks every latency, strobe count and bank_open state, with zero mismatches.
